dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 32-bit data RAM (32768 words, byte-lane write) between the CPU load/store
//  unit and a DMA/loader port. Per-cycle arbitration, byte-enable pass-through, read-return routing,
//  out-of-range rejection. Sits between the CPU memory stage / DMA engine and the data RAM.
// PARAMETERS
//  AW         15  RAM word-address width (word index = addr[AW+1:2])
//  CPU_BURST  4   max consecutive CPU grants while DMA waits before DMA is forced one slot (1..15)
// PORTS
//  clk         in   1   clock, all logic rising-edge
//  rst_n       in   1   asynchronous active-low reset
//  cpu_req     in   1   CPU access request, held until granted
//  cpu_we      in   1   1=store, 0=load
//  cpu_addr    in   32  byte address
//  cpu_be      in   4   byte lanes (store); ignored for load
//  cpu_wdata   in   32  store data, already lane-aligned
//  cpu_gnt     out  1   comb.; request accepted this cycle
//  cpu_rvalid  out  1   response valid (load data or store ack)
//  cpu_rdata   out  32  load word, valid with cpu_rvalid
//  cpu_err     out  1   response is an out-of-range error, valid with cpu_rvalid
//  dma_*       -    -   identical set: dma_req, dma_we, dma_addr, dma_be, dma_wdata, dma_gnt,
//                       dma_rvalid, dma_rdata, dma_err
//  mem_en      out  1   RAM access strobe
//  mem_addr    out  AW  RAM word index
//  mem_we      out  4   per-byte write enable (be & {4{we}})
//  mem_wdata   out  32  RAM write data
//  mem_rdata   in   32  RAM read data, 1 cycle after mem_en (registered RAM)
// BEHAVIOUR
//  - Reset: all *_gnt, *_rvalid, *_err, mem_en, mem_we = 0; rdata outputs = 0; starve_cnt = 0; owner = NONE.
//  - Exactly one grant per cycle max; mem_* driven combinationally from granted requester same cycle.
//  - Priority: CPU over DMA, except when starve_cnt == CPU_BURST and dma_req=1 -> DMA granted.
//  - starve_cnt: +1 on CPU grant while dma_req=1 (saturates at CPU_BURST); clears on DMA grant or
//    when dma_req=0.
//  - Response latency exactly 1 cycle after grant for both loads and stores; rvalid is a 1-cycle pulse.
//    rdata = mem_rdata routed by registered owner; stores return rdata=0.
//  - Back-to-back grants to either port allowed every cycle; no pipeline bubble on owner switch.
//  - Out-of-range: addr[31:AW+2] != 0 -> granted normally, mem_en=0, response next cycle with err=1,
//    rdata=0. No RAM write occurs.
//  - Alignment is the requester's responsibility; arbiter forwards be unchanged. be=0 store is a legal no-op
//    write (mem_en=1, mem_we=0), still acked.
//  - Simultaneous req from both with starve_cnt < CPU_BURST: CPU granted, DMA waits (gnt=0, must hold).
//  - Reset asserted mid-access: pending response discarded, no rvalid after reset release.
//  - gnt depends only on req + internal state, never on we/addr (no comb. loop through requesters).
// CONFIGURATION
//  DMEM_ARB_STATS_EN: when defined, adds outputs stat_cpu_gnt[31:0], stat_dma_gnt[31:0],
//  stat_conflict[31:0] (cycles both req high), stat_err[31:0]; wrapping counters, reset to 0 by rst_n.
//  When undefined, ports and counters are absent; all other behaviour identical.
// TESTING
//  1 CPU load 0x0000_0104 only, RAM[0x41]=0xDEADBEEF -> gnt cycle 0, mem_addr=0x41, cpu_rvalid cycle 1,
//    cpu_rdata=0xDEADBEEF, cpu_err=0.
//  2 DMA store addr 0x8, be=4'b0100, wdata=0x00AB0000 -> mem_we=4'b0100, mem_addr=2; following CPU load
//    of 0x8 returns byte 2 = 0xAB, other bytes unchanged.
//  3 Both req held 20 cycles, CPU_BURST=4 -> grant pattern C,C,C,C,D repeating; dma_gnt every 5th cycle.
//  4 CPU load 0x0002_0000 (AW=15) -> mem_en=0, cpu_rvalid+cpu_err=1 next cycle, cpu_rdata=0, RAM unchanged.
//  5 CPU load granted, rst_n low before response edge -> cpu_rvalid stays 0 through and after reset.
//  6 DMEM_ARB_STATS_EN build, scenario 3 for 20 cycles -> stat_cpu_gnt=16, stat_dma_gnt=4,
//    stat_conflict=20, stat_err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port byte-lane data RAM between the CPU load/store unit and a DMA port.
//   Optional feature macro: DMEM_ARB_STATS_EN (adds grant/conflict/error statistics counters).
//   Ports: clk_i, rst_ni (async active-low); cpu_*/dma_* request side (req, we, addr, be, wdata in;
//   gnt, rvalid, rdata, err out); mem_* RAM side (en, addr, we, wdata out; rdata in, 1-cycle latency);
//   stat_* counters when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int AW        = 15,
  parameter int CPU_BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [3:0]    cpu_be_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_err_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [31:0]   dma_addr_i,
  input  logic [3:0]    dma_be_i,
  input  logic [31:0]   dma_wdata_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [31:0]   dma_rdata_o,
  output logic          dma_err_o,
  output logic          mem_en_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_we_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_cpu_gnt_o,
  output logic [31:0]   stat_dma_gnt_o,
  output logic [31:0]   stat_conflict_o,
  output logic [31:0]   stat_err_o
`endif
);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;
  owner_e      owner_q, owner_d;
  logic        ld_q, ld_d, err_q, err_d;
  logic [3:0]  starve_q, starve_d;
  logic        force_dma, any_gnt, oor, sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  // Grants look only at the req lines and starve_q, so no path from we/addr back to gnt.
  always_comb begin
    force_dma   = dma_req_i && (starve_q == 4'(CPU_BURST));
    cpu_gnt_o   = cpu_req_i && !force_dma;
    dma_gnt_o   = dma_req_i && !cpu_gnt_o;
    any_gnt     = cpu_gnt_o || dma_gnt_o;
    sel_we      = cpu_gnt_o ? cpu_we_i : dma_we_i;
    sel_addr    = cpu_gnt_o ? cpu_addr_i : dma_addr_i;
    sel_be      = cpu_gnt_o ? cpu_be_i : dma_be_i;
    sel_wdata   = cpu_gnt_o ? cpu_wdata_i : dma_wdata_i;
    oor         = |(sel_addr >> (AW + 2));
    mem_en_o    = any_gnt && !oor;
    mem_addr_o  = sel_addr[AW+1:2];
    mem_we_o    = mem_en_o ? (sel_be & {4{sel_we}}) : 4'b0;
    mem_wdata_o = sel_wdata;
    owner_d     = cpu_gnt_o ? OWN_CPU : dma_gnt_o ? OWN_DMA : OWN_NONE;
    ld_d        = mem_en_o && !sel_we;
    err_d       = any_gnt && oor;
    starve_d    = (!dma_req_i || dma_gnt_o) ? 4'd0 :
                  (cpu_gnt_o && starve_q != 4'(CPU_BURST)) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= OWN_NONE;
      ld_q     <= 1'b0;
      err_q    <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      ld_q     <= ld_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end
  // RAM data arrives the cycle after the grant, so it is steered by the registered owner.
  always_comb begin
    cpu_rvalid_o = owner_q == OWN_CPU;
    dma_rvalid_o = owner_q == OWN_DMA;
    cpu_err_o    = cpu_rvalid_o && err_q;
    dma_err_o    = dma_rvalid_o && err_q;
    cpu_rdata_o  = (cpu_rvalid_o && ld_q) ? mem_rdata_i : 32'b0;
    dma_rdata_o  = (dma_rvalid_o && ld_q) ? mem_rdata_i : 32'b0;
  end
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] st_cpu_q, st_dma_q, st_conf_q, st_err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_cpu_q  <= 32'd0;
      st_dma_q  <= 32'd0;
      st_conf_q <= 32'd0;
      st_err_q  <= 32'd0;
    end else begin
      st_cpu_q  <= st_cpu_q + {31'b0, cpu_gnt_o};
      st_dma_q  <= st_dma_q + {31'b0, dma_gnt_o};
      st_conf_q <= st_conf_q + {31'b0, cpu_req_i && dma_req_i};
      st_err_q  <= st_err_q + {31'b0, err_d};
    end
  end
  assign stat_cpu_gnt_o  = st_cpu_q;
  assign stat_dma_gnt_o  = st_dma_q;
  assign stat_conflict_o = st_conf_q;
  assign stat_err_o      = st_err_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a registered byte-lane RAM model.
//   Build with DMEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_dmem_arbiter;
  logic        clk = 1'b0, rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_be, dma_be;
  logic        cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en;
  logic [14:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] st_cpu, st_dma, st_conf, st_err;
`endif
  logic [31:0] ram [32768];
  logic [31:0] ref_mem [32768];
  logic [32:0] cpu_q [$];
  logic [32:0] dma_q [$];
  logic [32:0] e;
  int          n_tests = 0, n_fail = 0;
  logic        cg, dg;
  always #5 clk = ~clk;
  dmem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_be_i(cpu_be),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
    .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_be_i(dma_be),
    .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid),
    .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu_gnt_o(st_cpu), .stat_dma_gnt_o(st_dma), .stat_conflict_o(st_conf), .stat_err_o(st_err)
`endif
  );
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) if (mem_we[b]) ram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
      mem_rdata <= ram[mem_addr];
    end
  end
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Reference behaviour: {err, rdata} response for one granted access; stores update ref_mem.
  function automatic logic [32:0] model(input logic we, input logic [31:0] a, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [14:0] w = a[16:2];
    if (a[31:17] != 15'd0) return {1'b1, 32'b0};
    if (!we) return {1'b0, ref_mem[w]};
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b+:8] = wd[8*b+:8];
    return 33'b0;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      cpu_q.delete();
      dma_q.delete();
    end else begin
      if (cpu_q.size() != 0) begin
        e = cpu_q.pop_front();
        check("cpu_rvalid", {32'b0, cpu_rvalid}, 33'd1);
        check("cpu_rsp", {cpu_err, cpu_rdata}, e);
      end else check("cpu_idle", {32'b0, cpu_rvalid}, 33'd0);
      if (dma_q.size() != 0) begin
        e = dma_q.pop_front();
        check("dma_rvalid", {32'b0, dma_rvalid}, 33'd1);
        check("dma_rsp", {dma_err, dma_rdata}, e);
      end else check("dma_idle", {32'b0, dma_rvalid}, 33'd0);
      check("one_gnt", {32'b0, cpu_gnt & dma_gnt}, 33'd0);
      if (cpu_gnt) cpu_q.push_back(model(cpu_we, cpu_addr, cpu_be, cpu_wdata));
      if (dma_gnt) dma_q.push_back(model(dma_we, dma_addr, dma_be, dma_wdata));
    end
  end
  task automatic start(input bit p, input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    int n = 0;
    @(posedge clk); #1;
    if (!p) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
    end else begin
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_be = be; dma_wdata = wd;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? dma_gnt : cpu_gnt) && n < 20);
    check("gnt_wait", {32'b0, p ? dma_gnt : cpu_gnt}, 33'd1);
  endtask
  task automatic drop(input bit p);
    @(posedge clk); #1;
    if (!p) cpu_req = 1'b0; else dma_req = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic idle_checks(input string tag);
    check({tag, "_cgnt"}, {32'b0, cpu_gnt}, 33'd0);
    check({tag, "_dgnt"}, {32'b0, dma_gnt}, 33'd0);
    check({tag, "_crv"}, {31'b0, cpu_rvalid, cpu_err}, 33'd0);
    check({tag, "_drv"}, {31'b0, dma_rvalid, dma_err}, 33'd0);
    check({tag, "_crd"}, {1'b0, cpu_rdata}, 33'd0);
    check({tag, "_drd"}, {1'b0, dma_rdata}, 33'd0);
    check({tag, "_mem"}, {28'b0, mem_en, mem_we}, 33'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = '0; dma_addr = '0; cpu_be = '0; dma_be = '0; cpu_wdata = '0; dma_wdata = '0;
    for (int i = 0; i < 32768; i++) begin
      ram[i] = (i * 32'h9E3779B9) ^ 32'hA5A5_0000;
      ref_mem[i] = ram[i];
    end
    ram[32'h41] = 32'hDEADBEEF; ref_mem[32'h41] = 32'hDEADBEEF;
    ram[2] = 32'h11223344;      ref_mem[2] = 32'h11223344;
    @(negedge clk);
    idle_checks("rst_in");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle_checks("rst_out");
    start(0, 1'b0, 32'h0000_0104, 4'hF, 32'h0);
    check("t1_addr", {18'b0, mem_addr}, 33'h41);
    check("t1_en", {28'b0, mem_en, mem_we}, 33'h10);
    drop(0);
    @(negedge clk);
    check("t1_rsp", {cpu_rvalid, cpu_err, cpu_rdata}, {2'b10, 32'hDEADBEEF} );
    start(1, 1'b1, 32'h8, 4'b0100, 32'h00AB_0000);
    check("t2_we", {29'b0, mem_we}, 33'b0100);
    check("t2_addr", {18'b0, mem_addr}, 33'd2);
    drop(1);
    start(0, 1'b0, 32'h8, 4'hF, 32'h0);
    drop(0);
    @(negedge clk);
    check("t2_rdata", {1'b0, cpu_rdata}, {1'b0, 32'h11AB_3344});
    start(0, 1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF);
    check("be0", {28'b0, mem_en, mem_we}, 33'h10);
    drop(0);
    start(1, 1'b0, 32'h8, 4'hF, 32'h0);
    drop(1);
    start(0, 1'b0, 32'h0002_0000, 4'hF, 32'h0);
    check("t4_en", {32'b0, mem_en}, 33'd0);
    drop(0);
    @(negedge clk);
    check("t4_rsp", {cpu_rvalid, cpu_err, cpu_rdata}, {2'b11, 32'h0});
    start(1, 1'b1, 32'h0002_0000, 4'hF, 32'hCAFE_F00D);
    check("oor_st", {28'b0, mem_en, mem_we}, 33'd0);
    drop(1);
    start(0, 1'b0, 32'h0, 4'hF, 32'h0);
    drop(0);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10; dma_be = 4'hF; dma_wdata = 32'h1234_5678;
    @(negedge clk);
    check("sw_c", {31'b0, cpu_gnt, dma_gnt}, 33'b10);
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    check("sw_d", {31'b0, cpu_gnt, dma_gnt}, 33'b01);
    @(posedge clk); #1 dma_req = 1'b0;
    start(1, 1'b0, 32'h10, 4'hF, 32'h0);
    drop(1);
    cg = 1'b0; dg = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!cpu_req || cg) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
        cpu_be = 4'($urandom_range(0, 15)); cpu_wdata = $urandom;
        cpu_addr = ($urandom_range(0, 9) == 0) ? 32'h0004_0000 : 32'($urandom_range(0, 15)) << 2;
      end
      if (!dma_req || dg) begin
        dma_req = 1'($urandom_range(0, 1)); dma_we = 1'($urandom_range(0, 1));
        dma_be = 4'($urandom_range(0, 15)); dma_wdata = $urandom;
        dma_addr = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom_range(0, 15)) << 2;
      end
      @(negedge clk);
      cg = cpu_gnt; dg = dma_gnt;
    end
    @(posedge clk); #1 cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("arb_%0d", i), {31'b0, cpu_gnt, dma_gnt}, (i % 5 == 4) ? 33'b01 : 33'b10);
    end
    @(posedge clk); #1 cpu_req = 1'b0; dma_req = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    check("st_cpu", {1'b0, st_cpu}, 33'd16);
    check("st_dma", {1'b0, st_dma}, 33'd4);
    check("st_conf", {1'b0, st_conf}, 33'd20);
    check("st_err", {1'b0, st_err}, 33'd0);
`endif
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
    @(negedge clk);
    check("t5_gnt", {32'b0, cpu_gnt}, 33'd1);
    #1 rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("t5_in", {32'b0, cpu_rvalid}, 33'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_out", {32'b0, cpu_rvalid}, 33'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
